conv_layer_sched: RTL and testbench

Per-layer sequencer for the conv/pool datapath: sram_top, CCM_top and maxpooling. It accepts one layer configuration and runs the passes in order: weight load, convolution stream, drain, then max-pool write-back. Passes iterate over input-channel groups within each output-filter group. It sits between the host/DRAM control interface and the chip datapath, and replaces free-running start-driven sequencing.

---
 rtl/conv_layer_sched_pkg.sv | 20 ++
 rtl/conv_layer_sched_pass_counter.sv | 18 +
 rtl/conv_layer_sched.sv | 140 ++++++++++++++
 tb/tb_conv_layer_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/conv_layer_sched_pkg.sv
// conv_layer_sched_pkg: shared state encoding, sizes and config check for the layer sequencer
package conv_layer_sched_pkg;
    localparam int SIZE_W = 8;
    localparam int DRAIN_CYC_DEF = 4;
    localparam int CNT_W = 16;
    localparam int CHANNEL_OUT = 32;
    localparam int PEA_NUM = 4;
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        CONV   = 3'd2,
        DRAIN  = 3'd3,
        POOL   = 3'd4,
        NEXT   = 3'd5,
        DONE   = 3'd6
    } state_t;
    function automatic logic cfg_bad(input logic [SIZE_W-1:0] n, input logic [3:0] p, input logic [3:0] g);
        return (n < SIZE_W'(2)) || n[0] || (p == 4'd0) || (g == 4'd0);
    endfunction
endpackage

// File: rtl/conv_layer_sched_pass_counter.sv
// pass_counter: clearable up-counter that flags when it sits on its terminal value
module pass_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] term,
    output logic         tc
);
    logic [W-1:0] cnt_q, cnt_d;
    always_comb cnt_d = clr ? '0 : inc ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    assign tc = (cnt_q == term);
endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: per-layer sequencer stepping weight load, conv stream, drain and pooling
// over input-channel passes within each output-filter group.
module conv_layer_sched
    import conv_layer_sched_pkg::*;
#(
    parameter int DRAIN_CYC = DRAIN_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SIZE_W-1:0] cfg_size,
    input  logic [3:0]        cfg_in_passes,
    input  logic [3:0]        cfg_out_groups,
    input  logic              abort,
    output logic              w_req,
    input  logic              w_ack,
    output logic              weight_en,
    output logic              ccm_en,
    output logic              ccm_en_cnt,
    input  logic              sum_reg_valid,
    output logic              pool_start,
    input  logic              pool_done,
    output logic [SIZE_W-1:0] size_out,
    output logic              busy,
    output logic              layer_done,
    output logic              cfg_err,
    output logic [2:0]        state
);
    state_t state_q, state_d;
    logic [SIZE_W-1:0] size_q, size_d;
    logic [3:0] np_q, np_d, ng_q, ng_d;
    logic [CNT_W-1:0] nn_q, nn_d;
    logic weight_en_q, weight_en_d, pool_start_q, pool_start_d, cfg_err_q, cfg_err_d;
    logic accept, pix_tc, drn_tc, p_tc, g_tc, p_inc, g_inc, p_clr;

    always_comb begin
        state_d = state_q;
        size_d = size_q;
        np_d = np_q;
        ng_d = ng_q;
        nn_d = nn_q;
        weight_en_d = 1'b0;
        pool_start_d = 1'b0;
        cfg_err_d = 1'b0;
        accept = 1'b0;
        p_inc = 1'b0;
        g_inc = 1'b0;
        p_clr = 1'b0;
        case (state_q)
            IDLE: if (cfg_valid) begin
                if (cfg_bad(cfg_size, cfg_in_passes, cfg_out_groups)) cfg_err_d = 1'b1;
                else begin
                    accept = 1'b1;
                    size_d = cfg_size;
                    np_d = cfg_in_passes;
                    ng_d = cfg_out_groups;
                    nn_d = CNT_W'(cfg_size) * CNT_W'(cfg_size);
                    state_d = LOAD_W;
                end
            end
            LOAD_W: if (w_ack) begin
                weight_en_d = 1'b1;
                state_d = CONV;
            end
            CONV: if (sum_reg_valid && pix_tc) state_d = DRAIN;
            DRAIN: if (drn_tc) begin
                state_d = p_tc ? POOL : LOAD_W;
                p_inc = !p_tc;
                pool_start_d = p_tc;
            end
            POOL: if (pool_done) state_d = NEXT;
            NEXT: begin
                state_d = g_tc ? DONE : LOAD_W;
                g_inc = !g_tc;
                p_clr = !g_tc;
            end
            default: state_d = IDLE;
        endcase
        // abort overrides every transition and suppresses any pending pulse
        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            weight_en_d = 1'b0;
            pool_start_d = 1'b0;
            p_inc = 1'b0;
            g_inc = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            size_q <= '0;
            np_q <= '0;
            ng_q <= '0;
            nn_q <= '0;
            weight_en_q <= 1'b0;
            pool_start_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q <= size_d;
            np_q <= np_d;
            ng_q <= ng_d;
            nn_q <= nn_d;
            weight_en_q <= weight_en_d;
            pool_start_q <= pool_start_d;
            cfg_err_q <= cfg_err_d;
        end

    // pixel and drain counters restart whenever their state is not being (re)entered
    pass_counter #(.W(CNT_W)) u_pix (
        .clk(clk), .rst(rst), .clr(state_d != CONV), .inc(state_q == CONV && sum_reg_valid),
        .term(nn_q - CNT_W'(1)), .tc(pix_tc)
    );
    pass_counter #(.W(CNT_W)) u_drn (
        .clk(clk), .rst(rst), .clr(state_d != DRAIN), .inc(state_q == DRAIN),
        .term(CNT_W'(DRAIN_CYC - 1)), .tc(drn_tc)
    );
    pass_counter #(.W(4)) u_p (
        .clk(clk), .rst(rst), .clr(accept || p_clr || abort), .inc(p_inc),
        .term(np_q - 4'd1), .tc(p_tc)
    );
    pass_counter #(.W(4)) u_g (
        .clk(clk), .rst(rst), .clr(accept || abort), .inc(g_inc),
        .term(ng_q - 4'd1), .tc(g_tc)
    );

    assign cfg_ready = (state_q == IDLE);
    assign busy = (state_q != IDLE);
    assign w_req = (state_q == LOAD_W);
    assign ccm_en = (state_q == CONV);
    assign ccm_en_cnt = (state_q == CONV) || (state_q == DRAIN);
    assign layer_done = (state_q == DONE);
    assign weight_en = weight_en_q;
    assign pool_start = pool_start_q;
    assign cfg_err = cfg_err_q;
    assign size_out = size_q;
    assign state = state_q;
endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: directed and randomized layer runs against an event-count model
module tb_conv_layer_sched;
    import conv_layer_sched_pkg::*;
    logic clk = 0, rst = 1, cfg_valid = 0, abort = 0, w_ack = 0, sum_reg_valid = 0, pool_done = 0;
    logic [SIZE_W-1:0] cfg_size = '0;
    logic [3:0] cfg_in_passes = '0, cfg_out_groups = '0;
    logic cfg_ready, w_req, weight_en, ccm_en, ccm_en_cnt, pool_start, busy, layer_done, cfg_err;
    logic [SIZE_W-1:0] size_out;
    logic [2:0] state;
    int n_pass = 0, n_chk = 0;
    int hs = 0, we = 0, ps = 0, ld = 0, wr = 0, ce = 0;

    always #5 clk = ~clk;

    conv_layer_sched dut (
        .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_size(cfg_size),
        .cfg_in_passes(cfg_in_passes), .cfg_out_groups(cfg_out_groups), .abort(abort),
        .w_req(w_req), .w_ack(w_ack), .weight_en(weight_en), .ccm_en(ccm_en),
        .ccm_en_cnt(ccm_en_cnt), .sum_reg_valid(sum_reg_valid), .pool_start(pool_start),
        .pool_done(pool_done), .size_out(size_out), .busy(busy), .layer_done(layer_done),
        .cfg_err(cfg_err), .state(state)
    );

    always @(posedge clk) begin
        if (w_req && w_ack) hs++;
        if (w_req) wr++;
        if (weight_en) we++;
        if (pool_start) ps++;
        if (layer_done) ld++;
        if (ccm_en) ce++;
    end

    task automatic cyc(input int k = 1);
        repeat (k) @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic do_layer(input int n, input int p, input int g, input bit spur, input bit stop_pool);
        int h0, w0, p0, l0, c0, conv_cyc, cnt, d, early;
        h0 = hs; w0 = we; p0 = ps; l0 = ld; c0 = ce; conv_cyc = 0;
        cfg_size = SIZE_W'(n); cfg_in_passes = 4'(p); cfg_out_groups = 4'(g); cfg_valid = 1;
        cyc();
        cfg_valid = 0;
        check("w_req_after_cfg", w_req, 1);
        check("size_out", size_out, n);
        for (int gi = 0; gi < g; gi++) begin
            for (int pi = 0; pi < p; pi++) begin
                cyc($urandom_range(0, 2));
                check("w_req_held", w_req, 1);
                w_ack = 1;
                cyc();
                w_ack = 0;
                check("weight_en", weight_en, 1);
                check("ccm_en_start", ccm_en, 1);
                cnt = 0; early = 0;
                while (cnt < n * n) begin
                    sum_reg_valid = ($urandom_range(0, 2) != 0);
                    w_ack = spur && ($urandom_range(0, 1) == 1);
                    if (!ccm_en) early++;
                    cyc();
                    conv_cyc++;
                    if (sum_reg_valid) cnt++;
                end
                sum_reg_valid = 0; w_ack = 0;
                check("ccm_en_early_drop", early, 0);
                check("ccm_en_low", ccm_en, 0);
                check("ccm_en_cnt_drain", ccm_en_cnt, 1);
                check("drain_state", state, 3);
                d = 0;
                sum_reg_valid = spur;
                while (state == 3 && d < 20) begin
                    d++;
                    cyc();
                end
                sum_reg_valid = 0;
                check("drain_len", d, DRAIN_CYC_DEF);
                if (pi < p - 1) check("next_pass", state, 1);
                else begin
                    check("pool_start", pool_start, 1);
                    check("pool_state", state, 4);
                    if (stop_pool) return;
                    cyc($urandom_range(1, 3));
                    check("pool_start_width", pool_start, 0);
                    pool_done = 1;
                    cyc();
                    pool_done = 0;
                    check("next_state", state, 5);
                    cyc();
                    if (gi == g - 1) begin
                        check("layer_done", layer_done, 1);
                        cyc();
                        check("back_idle", state, 0);
                        check("layer_done_width", layer_done, 0);
                    end else check("next_group", state, 1);
                end
            end
        end
        check("w_handshakes", hs - h0, p * g);
        check("weight_en_pulses", we - w0, p * g);
        check("pool_starts", ps - p0, g);
        check("layer_dones", ld - l0, 1);
        check("ccm_en_cycles", ce - c0, conv_cyc);
    endtask

    task automatic bad_cfg(input int n, input int p, input int g);
        int w0;
        w0 = wr;
        cfg_size = SIZE_W'(n); cfg_in_passes = 4'(p); cfg_out_groups = 4'(g); cfg_valid = 1;
        cyc();
        cfg_valid = 0;
        check("cfg_err", cfg_err, 1);
        check("bad_state", state, 0);
        cyc(2);
        check("cfg_err_width", cfg_err, 0);
        check("bad_no_w_req", wr - w0, 0);
    endtask

    initial begin
        int l0;
        cyc(2);
        check("rst_state", state, 0);
        check("rst_cfg_ready", cfg_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_size_out", size_out, 0);
        check("rst_outs", {w_req, weight_en, ccm_en, ccm_en_cnt, pool_start, layer_done, cfg_err}, 0);
        rst = 0;
        cyc();
        do_layer(4, 1, 1, 0, 0);
        do_layer(2, 3, 2, 0, 0);
        bad_cfg(3, 1, 1);
        bad_cfg(0, 1, 1);
        bad_cfg(4, 0, 1);
        bad_cfg(4, 1, 0);
        bad_cfg(1, 2, 2);
        do_layer(4, 1, 1, 1, 0);
        // abort mid-convolution, then a fresh layer must need all of its pixels
        l0 = ld;
        cfg_size = 4; cfg_in_passes = 1; cfg_out_groups = 1; cfg_valid = 1;
        cyc();
        cfg_valid = 0; w_ack = 1;
        cyc();
        w_ack = 0; sum_reg_valid = 1;
        cyc(7);
        sum_reg_valid = 0;
        check("pre_abort_conv", state, 2);
        abort = 1;
        cyc();
        abort = 0;
        check("abort_state", state, 0);
        check("abort_ccm_en", ccm_en, 0);
        check("abort_no_done", ld - l0, 0);
        do_layer(4, 1, 1, 0, 0);
        do_layer(2, 15, 2, 0, 0);
        for (int i = 0; i < 6; i++)
            do_layer(2 * $urandom_range(1, 4), $urandom_range(1, 3), $urandom_range(1, 2), 1'($urandom_range(0, 1)), 0);
        // asynchronous reset between edges while pooling
        do_layer(2, 1, 1, 0, 1);
        l0 = ld;
        #2 rst = 1;
        #1;
        check("arst_state", state, 0);
        check("arst_cfg_ready", cfg_ready, 1);
        check("arst_size_out", size_out, 0);
        check("arst_outs", {busy, pool_start, ccm_en_cnt, w_req}, 0);
        #1 rst = 0;
        cyc();
        pool_done = 1;
        cyc();
        pool_done = 0;
        cyc(3);
        check("arst_pool_done_ignored", state, 0);
        check("arst_no_layer_done", ld - l0, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
